// File: rtl/mode_input_router_pkg.sv
// rtl/mode_input_router_pkg.sv - shared mode indices, characters and timing defaults
package mode_input_router_pkg;

  localparam int MODE_WATCH     = 0;
  localparam int MODE_SET       = 1;
  localparam int MODE_ALARM     = 2;
  localparam int MODE_STOPWATCH = 3;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // 10 ms debounce and 1 s long-press at a 50 MHz clock
  localparam int DEF_DEB_CYCLES  = 500000;
  localparam int DEF_LONG_CYCLES = 50000000;

endpackage

// File: rtl/mode_input_router_debounce.sv
// rtl/mode_input_router_debounce.sv - single-bit synchroniser and debouncer with rise pulse
module sw_debounce
  import mode_input_router_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  // two-flop synchroniser for the asynchronous raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level <= sync_b;
        rise  <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mode_input_router.sv
// rtl/mode_input_router.sv - debounced mode select with per-mode switch press/long-press routing
module mode_input_router
  import mode_input_router_pkg::*;
#(
  parameter int  N_MODES     = 4,
  parameter int  N_SW        = 4,
  parameter int  DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int  LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int  CHAR_W      = 8,
  localparam int MODE_W      = $clog2(N_MODES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_MODES-1:0]        mode_sel_in,
  input  logic [N_SW-1:0]           sw_in,
  input  logic [N_MODES*CHAR_W-1:0] char_in,
  output logic [N_SW-1:0]           sw_level,
  output logic [N_MODES*N_SW-1:0]   sw_press,
  output logic [N_MODES*N_SW-1:0]   sw_long,
  output logic [MODE_W-1:0]         mode,
  output logic                      mode_changed,
  output logic                      lockout,
  output logic [CHAR_W-1:0]         data_char
);

  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  logic [N_SW-1:0]    sw_rise;
  logic [N_MODES-1:0] dip_level;
  logic [N_MODES-1:0] dip_rise_unused;
  logic [MODE_W-1:0]  sel_mode;
  logic               lock_q;
  logic [HOLD_W-1:0]  hold_cnt [N_SW];
  logic [N_SW-1:0]    long_hit;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw_in[i]),
      .level (sw_level[i]),
      .rise  (sw_rise[i])
    );
  end

  for (genvar i = 0; i < N_MODES; i++) begin : g_dip_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (mode_sel_in[i]),
      .level (dip_level[i]),
      .rise  (dip_rise_unused[i])
    );
  end

  // lowest-index set DIP bit picks the mode; nothing set falls back to the watch mode
  always_comb begin
    sel_mode = MODE_W'(MODE_WATCH);
    for (int m = N_MODES - 1; m >= 0; m--) begin
      if (dip_level[m]) sel_mode = MODE_W'(m);
    end
  end

  // held buttons at a mode change keep routing off until every switch is released
  assign lockout = (lock_q | mode_changed) & (|sw_level);

  // register the selected mode, flag changes and remember an active lockout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode         <= '0;
      mode_changed <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      mode         <= sel_mode;
      mode_changed <= (sel_mode != mode);
      lock_q       <= lockout;
    end
  end

  // per-switch hold timers; a hit fires once when the hold reaches LONG_CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_SW; s++) hold_cnt[s] <= '0;
      long_hit <= '0;
    end else begin
      for (int s = 0; s < N_SW; s++) begin
        if (sw_level[s] && !lockout) begin
          if (hold_cnt[s] != HOLD_W'(LONG_CYCLES)) hold_cnt[s] <= hold_cnt[s] + HOLD_W'(1);
          long_hit[s] <= (hold_cnt[s] == HOLD_W'(LONG_CYCLES - 1));
        end else begin
          hold_cnt[s] <= '0;
          long_hit[s] <= 1'b0;
        end
      end
    end
  end

  // steer press and long-press pulses to the active mode's channel only
  always_comb begin
    sw_press = '0;
    sw_long  = '0;
    for (int m = 0; m < N_MODES; m++) begin
      if (mode == MODE_W'(m) && !lockout) begin
        sw_press[m*N_SW +: N_SW] = sw_rise;
        sw_long[m*N_SW +: N_SW]  = long_hit;
      end
    end
  end

  // shared LCD bus carries the active mode's character
  always_comb begin
    data_char = CHAR_W'(CHAR_SPACE);
    for (int m = 0; m < N_MODES; m++) begin
      if (mode == MODE_W'(m)) data_char = char_in[m*CHAR_W +: CHAR_W];
    end
  end

endmodule

// File: doc/mode_input_router.md
Name: mode_input_router

Overview:
- Parametrised successor to the top-level mode/switch multiplexing in the clock design.
- Debounces N_SW push switches and N_MODES mode-select DIP bits.
- Selects one active mode and routes one-cycle press and long-press pulses only to that mode's channel; inactive channels see zero.
- Muxes that mode's LCD character onto the shared driver bus, and blocks held-button bleed across a mode change with a release lockout.

Parameters:
N_MODES, 4, number of display/operating modes (≥2)
N_SW, 4, number of push switches
DEB_CYCLES, 500000, consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz)
LONG_CYCLES, 50000000, cycles a switch must stay held after acceptance to emit a long-press (1 s)
CHAR_W, 8, LCD character width
MODE_W, derived localparam = $clog2(N_MODES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
mode_sel_in  in  N_MODES  raw DIP mode select
sw_in  in  N_SW  raw push switches, active-high
char_in  in  N_MODES*CHAR_W  per-mode character; mode m at [m*CHAR_W +: CHAR_W]
sw_level  out  N_SW  debounced switch levels (unrouted)
sw_press  out  N_MODES*N_SW  press pulse; mode m, switch s at bit m*N_SW+s
sw_long  out  N_MODES*N_SW  long-press pulse, same indexing
mode  out  MODE_W  active mode index
mode_changed  out  1  one-cycle pulse when mode updates
lockout  out  1  high while routing is suppressed after a mode change
data_char  out  CHAR_W  character of active mode

Behaviour:
- Reset (async assert, sync release): every output and internal state is 0. This covers sync flops, counters, stable levels, mode, lockout, and all pulses. data_char therefore shows char_in slice 0.
- Debounce (per bit, all N_SW+N_MODES bits):
  - Input passes through a 2-flop synchroniser.
  - The counter clears whenever the synchronised value equals the stable value. Otherwise it increments.
  - When the counter reaches DEB_CYCLES-1 on a differing sample, the stable value flips and the counter clears.
  - Net latency from raw edge to stable edge is DEB_CYCLES+2 cycles. Glitches shorter than DEB_CYCLES cycles are ignored.
- Mode select (combinational on stable DIP bits):
  - Lowest-index set bit wins. All-zero selects mode 0.
  - The result is registered into mode.
  - When the new value differs from mode: mode updates, mode_changed pulses for 1 cycle, and lockout is set if any sw_level bit is 1 in that same cycle.
- Lockout:
  - Clears on the first cycle all sw_level bits are 0.
  - While lockout is set, sw_press and sw_long are all zero, and hold counters are cleared and held.
- Press:
  - The cycle sw_level[s] goes 0→1 with lockout=0, bit mode*N_SW+s of sw_press is 1 for exactly one cycle.
  - The registered mode value present in that cycle is used.
- Long press:
  - A per-switch hold counter runs while sw_level[s]=1 and lockout=0.
  - On reaching LONG_CYCLES, sw_long pulses once and the counter saturates.
  - No further long pulse occurs until release.
  - Release before LONG_CYCLES produces no long pulse.
  - A single press therefore yields both a press pulse and, if held, a long pulse.
- Simultaneous events:
  - A press edge in the same cycle as a mode change is suppressed, because the mode change takes priority and lockout is set since the level is 1.
  - Two switches pressing in the same cycle both pulse.
- Reset mid-hold: counters clear, no long pulse is emitted, and a press is required again after reset release.
- data_char = char_in[mode*CHAR_W +: CHAR_W], combinational from the registered mode. There is no latch on unselected channels.
- All counters are wide enough for their maximum value ($clog2(DEB_CYCLES+1), $clog2(LONG_CYCLES+1)). There is no wrap.

Decomposition:
- Shared package holds:
  - MODE_WATCH=0, MODE_SET=1, MODE_ALARM=2, MODE_STOPWATCH=3 index constants
  - CHAR_SPACE=8'h20
  - default DEB_CYCLES/LONG_CYCLES for 50 MHz
- One sub-module sw_debounce (parameter DEB_CYCLES): synchroniser + counter + stable flop, with outputs level and rise.
  - Instantiated in a generate loop N_SW+N_MODES times.
  - Replaces the fixed four debouncer instances.

Test Plan:
(bench params: N_MODES=4, N_SW=4, DEB_CYCLES=4, LONG_CYCLES=20, CHAR_W=8)
1. Reset with all inputs 0, char_in slice0=8'h41 → mode=0, data_char=8'h41, all pulses 0, lockout=0.
2. sw_in[1] high 3 cycles then low → sw_level[1] stays 0, no pulse. Then high 30 cycles → sw_level[1]=1 at cycle 6, sw_press[1] one pulse, sw_long[1] one pulse 20 cycles later, no repeat.
3. mode_sel_in=4'b0110 → mode=1 after 6 cycles, mode_changed one pulse, data_char=char_in slice1. A later sw_in[0] press pulses sw_press[4] only.
4. Hold sw_in[2] in mode 0, switch mode_sel_in to 4'b0100 → mode=2, lockout=1, no sw_press[10] or sw_long[10]. Release sw_in[2] → lockout=0 after debounce. Next press pulses sw_press[10].
5. mode_sel_in=0 from mode 3 → mode=0, mode_changed pulses. 2-cycle glitch on mode_sel_in[3] → no mode change.
6. Assert rst at hold count 10 on sw_in[3] → all outputs 0 immediately. After release with sw_in[3] still high → press pulse after 6 cycles; long pulse only after a further 20 cycles.
